// File: rtl/fetch_unit.sv
// Decoupled fetch stage: sequential imem requests under a DEPTH credit limit, in-order
// responses buffered in a {pc, inst} queue for decode. Optional macro FETCH_BYPASS_EN.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_inst
);
   localparam int            AW      = $clog2(DEPTH);
   localparam int            CW      = AW + 1;
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   discard_q, discard_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   ipc_rd_q, ipc_rd_d, ipc_wr_q, ipc_wr_d;

   logic [XLEN-1:0] q_pc_mem   [DEPTH];
   logic [XLEN-1:0] q_inst_mem [DEPTH];
   logic [XLEN-1:0] ipc_mem    [DEPTH];

   logic [CW:0]     credit_used;
   logic            head_valid, resp_keep, grant_fire, push, pop, bypass_fire;
   logic [XLEN-1:0] resp_pc;

   assign resp_pc     = ipc_mem[ipc_rd_q];
   assign head_valid  = (count_q != '0);
   assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
   assign imem_req    = !redirect && (credit_used < DEPTH_C);
   assign imem_addr   = fetch_pc_q;
   assign grant_fire  = imem_req && imem_gnt;
   // Responses owed to a pre-redirect stream, or arriving during a redirect, are dropped.
   assign resp_keep   = imem_rvalid && (discard_q == '0) && !redirect;

   always_comb begin
      id_valid    = head_valid && !redirect;
      id_pc       = head_valid ? q_pc_mem[rd_ptr_q]   : '0;
      id_inst     = head_valid ? q_inst_mem[rd_ptr_q] : '0;
      bypass_fire = 1'b0;
`ifdef FETCH_BYPASS_EN
      if (!head_valid && resp_keep) begin
         id_valid    = 1'b1;
         id_pc       = resp_pc;
         id_inst     = imem_rdata;
         bypass_fire = id_ready;
      end
`endif
   end

   assign pop  = head_valid && id_valid && id_ready;
   assign push = resp_keep && !bypass_fire;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_q + CW'(grant_fire) - CW'(imem_rvalid);
      discard_d  = discard_q - CW'(imem_rvalid && (discard_q != '0));
      count_d    = count_q + CW'(push) - CW'(pop);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      wr_ptr_d   = wr_ptr_q + AW'(push);
      ipc_wr_d   = ipc_wr_q + AW'(grant_fire);
      ipc_rd_d   = ipc_rd_q + AW'(imem_rvalid);
      if (grant_fire) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (redirect) begin
         // Everything still outstanding after this cycle belongs to the old stream.
         fetch_pc_d = redirect_pc & ~(XLEN'(3));
         discard_d  = inflight_q - CW'(imem_rvalid);
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         ipc_rd_q   <= '0;
         ipc_wr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         ipc_rd_q   <= ipc_rd_d;
         ipc_wr_q   <= ipc_wr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (grant_fire) begin
         ipc_mem[ipc_wr_q] <= fetch_pc_q;
      end
      if (push) begin
         q_pc_mem[wr_ptr_q]   <= resp_pc;
         q_inst_mem[wr_ptr_q] <= imem_rdata;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes expected {pc, inst} per redirect/stream,
// a monitor pops and compares on every id_valid && id_ready.
module tb_fetch_unit;
`ifdef FETCH_BYPASS_EN
   localparam int EXP_FIRST = 1;
`else
   localparam int EXP_FIRST = 2;
`endif

   logic        clock, reset, redirect, imem_req, imem_gnt, imem_rvalid;
   logic        id_valid, id_ready;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, id_pc, id_inst;

   fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct { logic [31:0] addr; int due; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
   req_t memq[$];
   exp_t sb[$];

   int vectors = 0, miscompares = 0;
   int cyc = 0, fires = 0, first_fire = -1, last_fire = -1, grants = 0;
   int lat_min = 1, lat_max = 1, gnt_pct = 100;
   bit ready_en = 1'b1, rand_ready = 1'b0;
   logic        last_req, last_valid;
   logic [31:0] last_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, a[15:0] ^ 16'h1234};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         sb.push_back('{pc: start + 32'(4 * i), inst: mem_word(start + 32'(4 * i))});
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
      memq.delete();
      sb.delete();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      cyc = 0; fires = 0; first_fire = -1; last_fire = -1; grants = 0;
   endtask

   // One cycle: drive at the negedge, sample outputs 1ns later, advance to the next negedge.
   task automatic step(input bit redir, input logic [31:0] rpc);
      int d;
      redirect = redir;
      redirect_pc = rpc;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(memq[0].addr);
         void'(memq.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      imem_gnt = (gnt_pct >= 100) ? 1'b1 : ($urandom_range(99) < gnt_pct);
      id_ready = ready_en && (sb.size() > 0) && (!rand_ready || ($urandom_range(1) == 1));
      #1;
      last_req = imem_req; last_addr = imem_addr; last_valid = id_valid;
      if (imem_req && imem_gnt) begin
         d = cyc + int'($urandom_range(lat_max, lat_min));
         memq.push_back('{addr: imem_addr, due: d});
         grants++;
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0, 32'h0);
   endtask

   always @(negedge clock) begin
      exp_t e;
      #2;
      if (!reset && id_valid && id_ready) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL deliver_unexpected: got pc %h, expected no delivery", id_pc);
         end else begin
            e = sb.pop_front();
            if (id_pc !== e.pc || id_inst !== e.inst) begin
               miscompares++;
               $display("FAIL deliver: got pc %h inst %h, expected pc %h inst %h",
                        id_pc, id_inst, e.pc, e.inst);
            end
         end
         fires++;
         if (first_fire < 0) first_fire = cyc;
         last_fire = cyc;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] next_exp, tgt;
      bit rd;
      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;

      // Reset state
      @(negedge clock); #1;
      check("rst_imem_req", 32'(imem_req), 32'h1);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_id_valid", 32'(id_valid), 32'h0);
      check("rst_id_pc", id_pc, 32'h0);
      check("rst_id_inst", id_inst, 32'h0);
      @(negedge clock);

      // Zero-wait streaming
      do_reset();
      lat_min = 1; lat_max = 1; gnt_pct = 100; ready_en = 1'b1; rand_ready = 1'b0;
      push_seq(32'h0, 16);
      run(22);
      check("stream_first_cycle", 32'(first_fire), 32'(EXP_FIRST));
      check("stream_last_cycle", 32'(last_fire), 32'(EXP_FIRST + 15));
      check("stream_count", 32'(fires), 32'd16);

      // Decode stall: credits cap grants at DEPTH, then drain in order
      do_reset();
      ready_en = 1'b0;
      push_seq(32'h0, 8);
      run(10);
      check("hold_grants", 32'(grants), 32'd4);
      check("hold_req_dropped", 32'(last_req), 32'h0);
      ready_en = 1'b1;
      run(15);
      check("hold_drain_count", 32'(fires), 32'd8);
      check("hold_sb_empty", 32'(sb.size()), 32'h0);

      // 3-cycle memory, 2 in flight, redirect to 0x100
      do_reset();
      lat_min = 3; lat_max = 3;
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);
      push_seq(32'h100, 4);
      step(1'b1, 32'h100);
      check("redir_req_low", 32'(last_req), 32'h0);
      check("redir_valid_low", 32'(last_valid), 32'h0);
      check("redir_grants", 32'(grants), 32'd2);
      step(1'b0, 32'h0);
      check("redir_first_addr", last_addr, 32'h100);
      check("redir_first_req", 32'(last_req), 32'h1);
      run(15);
      check("redir_count", 32'(fires), 32'd4);

      // Redirect coinciding with rvalid and an offered grant
      do_reset();
      lat_min = 1; lat_max = 1;
      step(1'b0, 32'h0);
      push_seq(32'h200, 4);
      step(1'b1, 32'h200);
      check("redir_rv_req_low", 32'(last_req), 32'h0);
      check("redir_rv_valid_low", 32'(last_valid), 32'h0);
      check("redir_rv_grants", 32'(grants), 32'd1);
      step(1'b0, 32'h0);
      check("redir_rv_addr", last_addr, 32'h200);
      check("redir_rv_req", 32'(last_req), 32'h1);
      run(10);
      check("redir_rv_count", 32'(fires), 32'd4);

      // Random grant/ready/latency with occasional redirects
      do_reset();
      lat_min = 1; lat_max = 3; gnt_pct = 50; rand_ready = 1'b1; ready_en = 1'b1;
      next_exp = 32'h0;
      for (int i = 0; i < 10000; i++) begin
         rd  = ($urandom_range(99) < 3);
         tgt = 32'($urandom_range(1023)) << 2;
         if (rd) begin
            sb.delete();
            next_exp = tgt;
         end
         while (sb.size() < 2) begin
            sb.push_back('{pc: next_exp, inst: mem_word(next_exp)});
            next_exp += 32'd4;
         end
         step(rd, tgt);
      end
      check("rand_progress", 32'(fires > 1000), 32'h1);

      // Reset mid-burst with 3 requests in flight
      do_reset();
      lat_min = 3; lat_max = 3; gnt_pct = 100; rand_ready = 1'b0; ready_en = 1'b0;
      run(3);
      check("burst_grants", 32'(grants), 32'd3);
      reset = 1'b1; imem_rvalid = 1'b0; imem_gnt = 1'b0;
      memq.delete();
      #1;
      check("midrst_addr", imem_addr, 32'h0);
      check("midrst_valid", 32'(id_valid), 32'h0);
      check("midrst_req", 32'(imem_req), 32'h1);
      @(negedge clock);
      do_reset();
      lat_min = 1; lat_max = 1; ready_en = 1'b1;
      push_seq(32'h0, 4);
      run(10);
      check("post_rst_first", 32'(first_fire), 32'(EXP_FIRST));
      check("post_rst_count", 32'(fires), 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
